qp_derive_pipe: RTL

- Parametrised, pipelined successor to the combinational chroma QP mapper in rec_tq.
- Per request, takes the luma QP, component select, and PPS/slice chroma offsets.
- Produces the final component QP (QP'), plus QP'/6 (per) and QP'%6 (rem), which the quantiser and dequantiser consume directly.
- Supports 4:2:0 table mapping and the 4:2:2/4:4:4 clip-only mode, extended bit-depth QP offset, and a valid/ready handshake with full backpressure.

---
 rtl/qp_derive_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/qp_derive_pipe.sv
// qp_derive_pipe: two-stage pipelined component QP derivation.
// Stage 1 applies the chroma offset and clips to qPi. Stage 2 maps qPi to the
// final QP' and splits it into per (QP'/6) and rem (QP'%6) for the quantiser.
// Handshake is valid/ready with full backpressure. Flush drops everything in
// flight, including a request presented in the same cycle.
module qp_derive_pipe #(
  parameter int QP_W         = 7,
  parameter int QP_BD_OFFSET = 0,
  parameter int OFS_W        = 5,
  parameter int PER_W        = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [QP_W-1:0]  qp_y_i,
  input  logic        [1:0]       sel_i,
  input  logic signed [OFS_W-1:0] cb_ofs_i,
  input  logic signed [OFS_W-1:0] cr_ofs_i,
  input  logic                    chroma_fmt_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic        [QP_W-1:0]  qp_o,
  output logic        [PER_W-1:0] per_o,
  output logic        [2:0]       rem_o,
  output logic        [1:0]       sel_o
);

  // qPi is carried with two guard bits so qp_y + offset cannot wrap before clipping.
  localparam int IW = QP_W + 2;
  localparam logic signed [IW-1:0] QPI_MIN = IW'(-QP_BD_OFFSET);
  localparam logic signed [IW-1:0] QPI_MAX = IW'(57);
  localparam logic signed [IW-1:0] QP_MAX  = IW'(51);
  localparam logic signed [IW-1:0] TAB_LO  = IW'(30);
  localparam logic signed [IW-1:0] TAB_HI  = IW'(43);
  localparam logic signed [IW-1:0] BD_OFS  = IW'(QP_BD_OFFSET);

  // Saturate the offset-adjusted luma QP into the qPi range.
  function automatic logic signed [IW-1:0] clip_qpi(input logic signed [IW-1:0] v);
    if (v < QPI_MIN) return QPI_MIN;
    if (v > QPI_MAX) return QPI_MAX;
    return v;
  endfunction

  // Component QP from qPi: luma and reserved pass through, chroma is either
  // clipped at 51 (4:2:2/4:4:4) or mapped through the 4:2:0 table.
  function automatic logic signed [IW-1:0] map_qp(input logic signed [IW-1:0] qpi,
                                                  input logic [1:0] sel,
                                                  input logic fmt);
    logic signed [IW-1:0] q;
    q = qpi;
    if (sel == 2'd1 || sel == 2'd2) begin
      if (fmt) begin
        if (qpi > QP_MAX) q = QP_MAX;
      end else if (qpi > TAB_HI) begin
        q = qpi - IW'(6);
      end else if (qpi >= TAB_LO) begin
        case (int'(qpi))
          30:      q = IW'(29);
          31:      q = IW'(30);
          32:      q = IW'(31);
          33:      q = IW'(32);
          34, 35:  q = IW'(33);
          36, 37:  q = IW'(34);
          38, 39:  q = IW'(35);
          40, 41:  q = IW'(36);
          default: q = IW'(37);
        endcase
      end
    end
    return q;
  endfunction

  // Constant divide by 6 as multiply by 171/1024; exact for inputs below 512.
  function automatic logic [PER_W-1:0] div6(input logic [QP_W-1:0] x);
    logic [QP_W+7:0] prod;
    prod = (QP_W+8)'(x) * (QP_W+8)'(171);
    return PER_W'(prod >> 10);
  endfunction

  function automatic logic [2:0] mod6(input logic [QP_W-1:0] x);
    logic [QP_W+7:0] prod;
    logic [QP_W-1:0] quo;
    logic [QP_W-1:0] r;
    prod = (QP_W+8)'(x) * (QP_W+8)'(171);
    quo  = QP_W'(prod >> 10);
    r    = x - quo * QP_W'(6);
    return 3'(r);
  endfunction

  logic                   vld_p1, vld_p2;
  logic signed [IW-1:0]   qpi_p1;
  logic        [1:0]      sel_p1;
  logic                   fmt_p1;
  logic        [QP_W-1:0] qp_p2;
  logic        [PER_W-1:0] per_p2;
  logic        [2:0]      rem_p2;
  logic        [1:0]      sel_p2;

  logic                   stall;
  logic                   take;
  logic signed [IW-1:0]   qpy_ext;
  logic signed [IW-1:0]   ofs_ext;
  logic signed [IW-1:0]   qpi_c;
  logic signed [IW-1:0]   qfull_c;
  logic        [QP_W-1:0] qp_c;

  assign stall      = vld_p2 && !out_ready_i;
  assign in_ready_o = !(vld_p1 && stall);
  assign take       = in_valid_i && in_ready_o && !flush_i;

  // ---- stage 0 -> 1: offset select and qPi clip ----
  assign qpy_ext = IW'(qp_y_i);

  // Select the offset that applies to the requested component.
  always_comb begin
    ofs_ext = '0;
    case (sel_i)
      2'd1:    ofs_ext = IW'(cb_ofs_i);
      2'd2:    ofs_ext = IW'(cr_ofs_i);
      default: ofs_ext = '0;
    endcase
  end

  assign qpi_c = clip_qpi(qpy_ext + ofs_ext);

  // Stage-1 occupancy: cleared by flush, refilled whenever stage 1 may move.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            vld_p1 <= 1'b0;
    else if (flush_i)     vld_p1 <= 1'b0;
    else if (in_ready_o)  vld_p1 <= in_valid_i;
  end

  // Stage-1 data captured on accept only.
  always_ff @(posedge clk) begin
    if (take) begin
      qpi_p1 <= qpi_c;
      sel_p1 <= sel_i;
      fmt_p1 <= chroma_fmt_i;
    end
  end

  // ---- stage 1 -> 2: mapping, bit-depth offset, per/rem split ----
  assign qfull_c = map_qp(qpi_p1, sel_p1, fmt_p1) + BD_OFS;
  assign qp_c    = QP_W'(qfull_c);

  // Output occupancy: holds under stall, follows stage 1 otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        vld_p2 <= 1'b0;
    else if (flush_i) vld_p2 <= 1'b0;
    else if (!stall)  vld_p2 <= vld_p1;
  end

  // Output data: loaded when stage 1 moves forward, frozen while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qp_p2  <= '0;
      per_p2 <= '0;
      rem_p2 <= '0;
      sel_p2 <= '0;
    end else if (!stall && vld_p1) begin
      qp_p2  <= qp_c;
      per_p2 <= div6(qp_c);
      rem_p2 <= mod6(qp_c);
      sel_p2 <= sel_p1;
    end
  end

  assign out_valid_o = vld_p2;
  assign qp_o        = qp_p2;
  assign per_o       = per_p2;
  assign rem_o       = rem_p2;
  assign sel_o       = sel_p2;

endmodule
